// File: rtl/axil_pkg.sv
// axil_pkg: constants shared by the AXI-Lite master and the axil_ram slave.
//   RESP_OKAY / RESP_SLVERR : 2-bit BRESP/RRESP encodings
//   PROT_DEFAULT            : AxPROT value the master drives (the slave ignores it)
package axil_pkg;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/bram_be.sv
// bram_be: DEPTH x DATA_WIDTH simple dual-port RAM, written so that it
// infers block RAM.
//   clk      : clock, both ports on the rising edge
//   i_we     : write enable
//   i_waddr  : write word index
//   i_wbe    : byte-lane enables, one per 8 data bits
//   i_wdata  : write data
//   i_re     : read enable; o_rdata loads only when this is high
//   i_raddr  : read word index
//   o_rdata  : registered read data. A read and a write to the same word
//              on the same edge return the old contents.
// Contents are not reset.
module bram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [STRB_WIDTH-1:0] i_wbe,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (i_wbe[i]) r_mem[i_waddr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axil_ram.sv
// axil_ram: AXI-Lite slave memory that serves the core's instruction and
// data accesses. The memory is word-addressed and byte-writable.
//   clk, rst          : clock and asynchronous active-high reset
//   s_axil_aw*        : write address channel (awprot ignored)
//   s_axil_w*         : write data channel with byte strobes
//   s_axil_b*         : write response channel
//   s_axil_ar*        : read address channel (arprot ignored)
//   s_axil_r*         : read data channel
// Word index = addr[ADDR_LSB +: IDX_W].
// Optional feature macro: AXIL_RAM_ERR_RESP_EN. When it is defined, any address
// bit at or above ADDR_LSB+IDX_W makes the access out of range. An
// out-of-range access returns SLVERR, does not write memory, and reads as 0.
// When the macro is undefined, addresses wrap and every response is OKAY.
module axil_ram
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 4096,
  parameter int ADDR_LSB   = $clog2(STRB_WIDTH),
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  logic                  r_aw_full;
  logic [IDX_W-1:0]      r_aw_idx;
  logic                  r_aw_oor;
  logic                  r_w_full;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_WIDTH-1:0] r_w_strb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic                  r_rzero;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic                  w_aw_oor;
  logic                  w_ar_oor;
  logic                  w_unused;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

`ifdef AXIL_RAM_ERR_RESP_EN
  assign w_aw_oor = |s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB+IDX_W];
  assign w_ar_oor = |s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB+IDX_W];
  assign w_unused = &{1'b0, s_axil_awprot, s_axil_arprot,
                      s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};
`else
  assign w_aw_oor = 1'b0;
  assign w_ar_oor = 1'b0;
  assign w_unused = &{1'b0, s_axil_awprot, s_axil_arprot,
                      s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB+IDX_W],
                      s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB+IDX_W],
                      s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};
`endif

  // While reset is high, every ready output is forced low.
  assign s_axil_awready = !rst && !r_aw_full;
  assign s_axil_wready  = !rst && !r_w_full;
  assign s_axil_arready = !rst && (!r_rvalid || s_axil_rready);

  assign w_aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_w_hs   = s_axil_wvalid && s_axil_wready;
  assign w_ar_hs  = s_axil_arvalid && s_axil_arready;

  // A commit waits until the previous B response has been accepted.
  // At most one further AW and one further W can be held meanwhile.
  assign w_commit = r_aw_full && r_w_full && !r_bvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_aw_oor  <= 1'b0;
    end else if (w_aw_hs) begin
      r_aw_full <= 1'b1;
      r_aw_idx  <= s_axil_awaddr[ADDR_LSB +: IDX_W];
      r_aw_oor  <= w_aw_oor;
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_full <= 1'b0;
      r_w_data <= '0;
      r_w_strb <= '0;
    end else if (w_w_hs) begin
      r_w_full <= 1'b1;
      r_w_data <= s_axil_wdata;
      r_w_strb <= s_axil_wstrb;
    end else if (w_commit) begin
      r_w_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= r_aw_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (r_bvalid && s_axil_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // RAM output data cannot be reset, so r_rzero masks rdata to 0 after
  // reset and after an out-of-range read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rzero  <= 1'b1;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_ar_oor ? RESP_SLVERR : RESP_OKAY;
      r_rzero  <= w_ar_oor;
    end else if (r_rvalid && s_axil_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  bram_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .STRB_WIDTH (STRB_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bram (
    .clk     (clk),
    .i_we    (w_commit && !r_aw_oor),
    .i_waddr (r_aw_idx),
    .i_wbe   (r_w_strb),
    .i_wdata (r_w_data),
    .i_re    (w_ar_hs),
    .i_raddr (s_axil_araddr[ADDR_LSB +: IDX_W]),
    .o_rdata (w_ram_rdata)
  );

  assign s_axil_bvalid = r_bvalid;
  assign s_axil_bresp  = r_bresp;
  assign s_axil_rvalid = r_rvalid;
  assign s_axil_rresp  = r_rresp;
  assign s_axil_rdata  = r_rzero ? '0 : w_ram_rdata;

endmodule

// File: tb/tb_axil_ram.sv
// tb_axil_ram: directed, self-checking bench for axil_ram.
// Inputs are driven 1 time unit after each rising edge. Handshakes are
// sampled on the falling edge just before the next rising edge.
module tb_axil_ram;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = PROT_DEFAULT;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = PROT_DEFAULT;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int errors = 0;
  int checks = 0;

  bit          s_aw_hs, s_w_hs, s_ar_hs, s_b_hs, s_r_hs;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  logic [31:0] rd;
  logic [1:0]  rsp;
  logic [31:0] bb [4];

  always #5 clk = ~clk;

  axil_ram dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_aw_hs = awvalid && awready;
    s_w_hs  = wvalid && wready;
    s_ar_hs = arvalid && arready;
    s_b_hs  = bvalid && bready;
    s_r_hs  = rvalid && rready;
    s_bresp = bresp;
    s_rresp = rresp;
    s_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit done = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    resp = 2'b11;
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      if (s_aw_hs) awvalid = 1'b0;
      if (s_w_hs)  wvalid = 1'b0;
      if (s_b_hs) begin done = 1; resp = s_bresp; end
    end
    if (!done) begin
      check("write_timeout", 32'd0, 32'd1);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit done = 0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    data = 32'hFFFF_FFFF; resp = 2'b11;
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      if (s_ar_hs) arvalid = 1'b0;
      if (s_r_hs) begin done = 1; data = s_rdata; resp = s_rresp; end
    end
    if (!done) begin
      check("read_timeout", 32'd0, 32'd1);
      arvalid = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_rdata",   rdata,            32'd0);
    check("rst_resp",    {28'd0, bresp, rresp}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", {29'd0, awready, wready, arready}, 32'd7);

    // Full-word write then readback
    axi_write(32'h10, 32'hDEAD_BEEF, 4'b1111, rsp);
    check("w10_bresp", {30'd0, rsp}, 32'd0);
    axi_read(32'h10, rd, rsp);
    check("r10_data", rd, 32'hDEAD_BEEF);
    check("r10_rresp", {30'd0, rsp}, 32'd0);

    // AW arrives 3 cycles before W
    awaddr = 32'h20; awvalid = 1'b1; bready = 1'b0;
    tick();
    check("aw_first_hs", {31'd0, s_aw_hs}, 32'd1);
    awvalid = 1'b0;
    check("aw_held_awready", {31'd0, awready}, 32'd0);
    tick();
    check("aw_held_bvalid1", {31'd0, bvalid}, 32'd0);
    tick();
    check("aw_held_bvalid2", {31'd0, bvalid}, 32'd0);
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("w_accept_bvalid", {31'd0, bvalid}, 32'd0);
    tick();
    check("commit_bvalid", {31'd0, bvalid}, 32'd1);
    check("commit_bresp", {30'd0, bresp}, 32'd0);
    check("commit_ready", {30'd0, awready, wready}, 32'd3);
    bready = 1'b1;
    tick();
    check("b_done_bvalid", {31'd0, bvalid}, 32'd0);
    axi_read(32'h20, rd, rsp);
    check("r20_data", rd, 32'h1234_5678);

    // Partial strobe
    axi_write(32'h30, 32'hAABB_CCDD, 4'b1111, rsp);
    axi_write(32'h30, 32'h0000_1100, 4'b0010, rsp);
    check("w30_strb_bresp", {30'd0, rsp}, 32'd0);
    axi_read(32'h30, rd, rsp);
    check("r30_strb_data", rd, 32'hAABB_11DD);

    // Zero strobe: response but no change
    axi_write(32'h10, 32'h0BAD_F00D, 4'b0000, rsp);
    check("w10_zero_strb_bresp", {30'd0, rsp}, 32'd0);
    axi_read(32'h10, rd, rsp);
    check("r10_zero_strb_data", rd, 32'hDEAD_BEEF);

    // B backpressure with a second write held
    axi_write(32'h44, 32'h0, 4'hF, rsp);
    bready = 1'b0;
    awaddr = 32'h40; wdata = 32'h1111_1111; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("bp_first_bvalid", {31'd0, bvalid}, 32'd1);
    awaddr = 32'h44; wdata = 32'h2222_2222; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    check("bp_second_hs", {30'd0, s_aw_hs, s_w_hs}, 32'd3);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_bvalid", {31'd0, bvalid}, 32'd1);
      check("bp_hold_ready", {30'd0, awready, wready}, 32'd0);
      tick();
    end
    axi_read(32'h44, rd, rsp);
    check("bp_no_commit", rd, 32'h0);
    check("bp_still_bvalid", {31'd0, bvalid}, 32'd1);
    bready = 1'b1;
    tick();
    check("bp_first_hs", {31'd0, s_b_hs}, 32'd1);
    check("bp_gap_bvalid", {31'd0, bvalid}, 32'd0);
    tick();
    check("bp_second_bvalid", {31'd0, bvalid}, 32'd1);
    tick();
    check("bp_second_done", {31'd0, bvalid}, 32'd0);
    axi_read(32'h40, rd, rsp);
    check("r40_data", rd, 32'h1111_1111);
    axi_read(32'h44, rd, rsp);
    check("r44_data", rd, 32'h2222_2222);

    // Back-to-back reads, then R backpressure
    bb[0] = 32'hA000_0000; bb[1] = 32'hA111_1111;
    bb[2] = 32'hA222_2222; bb[3] = 32'hA333_3333;
    for (int i = 0; i < 4; i++) axi_write(32'(i * 4), bb[i], 4'hF, rsp);
    rready = 1'b1; arvalid = 1'b1; araddr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b2b_ar_hs", {31'd0, s_ar_hs}, 32'd1);
      check("b2b_rvalid", {31'd0, rvalid}, 32'd1);
      check("b2b_rdata", rdata, bb[i]);
      if (i < 3) araddr = 32'((i + 1) * 4);
      else arvalid = 1'b0;
    end
    rready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_arready", {31'd0, arready}, 32'd0);
      check("stall_rvalid", {31'd0, rvalid}, 32'd1);
      check("stall_rdata", rdata, bb[3]);
      tick();
    end
    rready = 1'b1;
    tick();
    check("stall_drain_rvalid", {31'd0, rvalid}, 32'd0);

    // Read and commit to the same word on the same edge
    axi_write(32'h60, 32'h0000_0001, 4'hF, rsp);
    awaddr = 32'h60; wdata = 32'h0000_0002; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h60; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    check("rbw_bvalid", {31'd0, bvalid}, 32'd1);
    check("rbw_old_data", rdata, 32'h0000_0001);
    rready = 1'b1;
    tick();
    axi_read(32'h60, rd, rsp);
    check("rbw_new_data", rd, 32'h0000_0002);

    // Address above the memory range
    axi_write(32'h4000, 32'h5A5A_5A5A, 4'hF, rsp);
`ifdef AXIL_RAM_ERR_RESP_EN
    check("oor_bresp", {30'd0, rsp}, {30'd0, RESP_SLVERR});
    axi_read(32'h4000, rd, rsp);
    check("oor_rdata", rd, 32'h0);
    check("oor_rresp", {30'd0, rsp}, {30'd0, RESP_SLVERR});
    axi_read(32'h0, rd, rsp);
    check("oor_word0", rd, bb[0]);
`else
    check("wrap_bresp", {30'd0, rsp}, 32'd0);
    axi_read(32'h4000, rd, rsp);
    check("wrap_rdata", rd, 32'h5A5A_5A5A);
    check("wrap_rresp", {30'd0, rsp}, 32'd0);
    axi_read(32'h0, rd, rsp);
    check("wrap_word0", rd, 32'h5A5A_5A5A);
`endif

    // Reset with AW held and a read response pending
    awaddr = 32'h50; awvalid = 1'b1; wvalid = 1'b0;
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    check("pre_rst_awready", {31'd0, awready}, 32'd0);
    check("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {29'd0, awready, wready, arready}, 32'd0);
    check("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst2_awready", {31'd0, awready}, 32'd1);
    wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick(); tick();
    check("post_rst2_no_commit", {31'd0, bvalid}, 32'd0);
    awaddr = 32'h54; awvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    check("post_rst2_commit", {31'd0, bvalid}, 32'd1);
    tick();
    axi_read(32'h54, rd, rsp);
    check("r54_data", rd, 32'h7777_7777);
    axi_read(32'h10, rd, rsp);
    check("r10_kept", rd, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_ram.md
Name: axil_ram

Overview:
AXI-Lite slave memory that sits directly downstream of the core's AXI-Lite master on the shared bus. It serves instruction and data accesses from a word-addressed, byte-writable synchronous RAM. The AW, W, B, AR and R channels follow AXI-Lite rules: AW and W arrive independently, and the master may hold B and R off with backpressure.

Parameters:
DATA_WIDTH, 32, bus data width in bits (multiple of 8)
ADDR_WIDTH, 32, bus byte-address width
STRB_WIDTH, DATA_WIDTH/8, write strobe width
DEPTH, 4096, memory depth in words (power of two)
ADDR_LSB, $clog2(STRB_WIDTH), byte-offset bits ignored in the word index
IDX_W, $clog2(DEPTH), word index width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awprot  in  3  ignored
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  DATA_WIDTH  write data
s_axil_wstrb  in  STRB_WIDTH  byte enables
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arprot  in  3  ignored
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  DATA_WIDTH  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready

Behaviour:
- Clocking and reset (decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0, aw_full=0, w_full=0.
- All ready outputs are forced to 0 while rst is high. Memory contents are not reset.
- Word index = addr[ADDR_LSB +: IDX_W]. Upper address bits and byte-offset bits are ignored, so addresses wrap modulo DEPTH words.

Write path:
- Two one-entry holding registers: AW (address) and W (data, strobe).
- awready = !aw_full; wready = !w_full.
- A beat is captured when valid&&ready; the matching full flag is set.
- Commit fires when aw_full && w_full && !bvalid:
  - mem[idx] is updated only in byte lanes with wstrb=1;
  - both full flags are cleared;
  - bvalid is set with bresp=OKAY.
- Latency: AW and W accepted at edge T, commit at edge T+1, bvalid high after T+1.
- AW and W may arrive in either order, any number of cycles apart.
- bvalid is held until bready; bresp is stable while bvalid=1.
- While bvalid is pending, at most one further AW and one further W are held; no further commit occurs until the B handshake completes.
- wstrb=0 commits no bytes but still produces a B response.

Read path:
- arready = !rvalid || rready.
- AR accepted at edge T: rdata <= mem[idx], rvalid=1 after T.
- rdata and rresp are held stable while rvalid && !rready.
- With rready continuously high, one read completes per cycle (back-to-back).
- A read and a write commit to the same word on the same edge: the read returns the old data (read-before-write).

Reset mid-operation:
- Held AW/W beats are discarded; pending B/R responses are dropped.
- A commit that completed on an earlier edge stays in memory.

Optional Feature:
- Macro AXIL_RAM_ERR_RESP_EN.
- Defined: an address with any bit at or above ADDR_LSB+IDX_W set is out of range.
  - Out-of-range writes drop the memory update and return bresp=SLVERR (10).
  - Out-of-range reads return rdata=0 and rresp=SLVERR.
- Undefined: addresses wrap modulo DEPTH and all responses are OKAY.

Decomposition:
- Package axil_pkg holds RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the prot default 3'b000 shared with the master.
- One sub-module, bram_be: a DEPTH x DATA_WIDTH dual-port RAM with one synchronous read port and one byte-enabled write port, inferable as block RAM.
- The handshake logic stays in axil_ram.

Test Plan:
- Write 0xDEADBEEF to 0x10 with wstrb=1111, then read 0x10 -> bresp=00, then rdata=0xDEADBEEF, rresp=00.
- AW for 0x20 presented 3 cycles before W 0x12345678 -> awready drops after AW capture, no bvalid until W is accepted, commit 1 cycle after W, readback correct.
- Preload 0xAABBCCDD at 0x30, write 0x00001100 with wstrb=0010 -> readback 0xAABB11DD.
- Hold bready=0 for 5 cycles after a write -> bvalid stays 1, second AW/W captured but not committed, second bvalid only after the first B handshake.
- Four back-to-back reads 0x0/0x4/0x8/0xC with rready=1 -> four consecutive rvalid cycles in order; then rready=0 for 3 cycles -> rdata stable, arready=0.
- Address 0x4000 with DEPTH=4096: with AXIL_RAM_ERR_RESP_EN -> bresp=10, rresp=10, rdata=0, word 0 unchanged; without it -> access aliases word 0, resp=00.
